rand_sampler: RTL and testbench
===============================

RAND_SAMPLER -- requirements
Module: rand_sampler

Interface
REQ-001 SHALL have parameter RANGE, default 6, number of output symbols (2..255); samples lie in 0..RANGE-1.
REQ-002 SHALL have parameter STRIDE, default 8, cycles between candidate draws (1..255), giving a fully refreshed 8-bit LFSR word per draw.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-006 rand_i  input  8  raw pseudo-random word from upstream LFSR, new value every cycle.
REQ-007 en_i  input  1  enables drawing candidates.
REQ-008 flush_i  input  1  synchronous clear of FIFO and stride counter.
REQ-009 sample_o  output  8  FIFO head sample, zero-extended.
REQ-010 valid_o  output  1  sample_o holds a valid sample.
REQ-011 ready_i  input  1  downstream accepts sample_o.
REQ-012 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL keep a stride counter 0..STRIDE-1 that increments each cycle while en_i=1 and FSM not HOLD, wraps at STRIDE-1, and holds otherwise.
REQ-014 Draw event: en_i=1, counter=STRIDE-1, state FILL; candidate = rand_i sampled on that edge.
REQ-015 Threshold T = 256 - (256 mod RANGE), a compile-time constant; candidate accepted iff candidate < T, else rejected and discarded.
REQ-016 Accepted candidate SHALL be pushed as candidate mod RANGE on the same edge; visible on valid_o/sample_o the following cycle (latency 1 from draw edge).
REQ-017 Pop occurs on any edge with valid_o=1 and ready_i=1; head advances, level_o decrements.
REQ-018 valid_o SHALL equal (level_o != 0); sample_o SHALL be 0 when level_o = 0.
REQ-019 FSM states: IDLE (en_i=0), FILL (en_i=1, not full), HOLD (FIFO full); IDLE->FILL on en_i=1; FILL->HOLD when a push makes level=DEPTH without a same-edge pop; HOLD->FILL when a pop leaves level<DEPTH; any state->IDLE on en_i=0.
REQ-020 In HOLD, no draws; stride counter frozen; a draw-eligible edge is lost, not deferred.
REQ-021 Simultaneous push and pop: level_o unchanged, both take effect; when full, pushes are blocked even with same-edge pop.
REQ-022 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-023 flush_i=1 SHALL clear level, pointers and stride counter on that edge; flush overrides push and pop; FSM goes to IDLE or FILL per en_i.

Reset
REQ-024 On rst_ni=0: level_o=0, valid_o=0, sample_o=0, pointers=0, stride counter=0, FSM=IDLE, immediately and asynchronously.
REQ-025 Reset mid-operation SHALL discard all buffered samples; first draw after release occurs STRIDE enabled cycles later.

Configuration
REQ-026 Macro RAND_SAMPLER_STATS_EN defined: adds output rejects_o [15:0], count of rejected candidates, saturating at 16'hFFFF, cleared by reset and flush_i.
REQ-027 Macro undefined: rejects_o port and its counter absent; all other behaviour identical.

Structure
REQ-028 FSM state enum and default parameter values SHALL live in shared package rand_pkg.
REQ-029 FIFO SHALL be a sub-module sample_fifo (storage, pointers, level); rand_sampler holds stride counter, accept logic and FSM.

Verification
REQ-030 RANGE=6, STRIDE=8, en_i=1, rand_i=251 at draw edge -> next cycle valid_o=1, sample_o=5, level_o=1.
REQ-031 RANGE=6, rand_i=252 at draw edge -> no push, level_o stays 0; with STATS_EN rejects_o increments by 1.
REQ-032 ready_i=0, en_i=1 for 5*STRIDE cycles, all accepted -> level_o=4, FSM HOLD; one pop -> level_o=3, next draw pushes after the counter resumes.
REQ-033 level_o=2, push and pop on same edge -> level_o=2, FIFO order preserved (first-in sample popped).
REQ-034 level_o=3, flush_i=1 with ready_i=1 -> next cycle level_o=0, valid_o=0, sample_o=0.
REQ-035 rst_ni driven low between clock edges with level_o=2 -> outputs zero without a clock edge; after release first push occurs no earlier than STRIDE cycles.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and defaults for the rejection-sampling random symbol generator.
package rand_pkg;

  localparam int RANGE_DEF  = 6;
  localparam int STRIDE_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Largest multiple of range that fits in an 8-bit word; candidates at or
  // above it would bias the modulo result, so they are rejected.
  function automatic int accept_threshold(input int range);
    return 256 - (256 % range);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small circular buffer holding accepted samples; head is zeroed when empty.
module sample_fifo
  import rand_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = empty_o ? 8'd0 : mem_q[rd_ptr_q];

  // Pointer and level update; flush wins over push and pop, pointers wrap mod DEPTH.
  always_comb begin
    push_ok  = push_i && !full_o && !flush_i;
    pop_ok   = pop_i && !empty_o && !flush_i;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers: pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents never observed while empty, so no reset needed.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rand_sampler.sv
// Rejection sampler: draws an LFSR word every STRIDE enabled cycles, keeps
// unbiased candidates as candidate mod RANGE and buffers them in a FIFO.
// Optional build macro RAND_SAMPLER_STATS_EN adds a saturating reject counter.
//
// state | meaning
// IDLE  | en_i low, no draws
// FILL  | enabled, FIFO has room, draws on stride terminal count
// HOLD  | FIFO full, draws and stride counter frozen
module rand_sampler
  import rand_pkg::*;
#(
  parameter int RANGE  = RANGE_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             rand_i,
  input  logic                   en_i,
  input  logic                   flush_i,
  output logic [7:0]             sample_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [$clog2(DEPTH):0] level_o
`ifdef RAND_SAMPLER_STATS_EN
  ,
  output logic [15:0]            rejects_o
`endif
);

  localparam int         LW          = $clog2(DEPTH) + 1;
  localparam logic [8:0] THRESH      = 9'(accept_threshold(RANGE));
  localparam logic [7:0] STRIDE_LAST = 8'(STRIDE - 1);
  localparam logic [7:0] RANGE_W     = 8'(RANGE);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          draw, cand_ok, push, pop;
  logic [7:0]    cand_mod;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: flush and en_i=0 override; HOLD entered only when a push fills the last slot.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = en_i ? ST_FILL : ST_IDLE;
    end else if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (push && !pop && fifo_level == LW'(DEPTH - 1)) state_d = ST_HOLD;
        ST_HOLD: if (pop) state_d = ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs of the FSM: draw/accept decision, push/pop strobes, stride counter next value.
  always_comb begin
    draw     = en_i && !flush_i && (state_q == ST_FILL) && (cnt_q == STRIDE_LAST);
    cand_ok  = ({1'b0, rand_i} < THRESH);
    cand_mod = rand_i % RANGE_W;
    push     = draw && cand_ok && !fifo_full;
    pop      = valid_o && ready_i && !flush_i;
    cnt_d    = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (en_i && state_q != ST_HOLD) begin
      cnt_d = (cnt_q == STRIDE_LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  // Stride counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

`ifdef RAND_SAMPLER_STATS_EN
  logic [15:0] rej_q, rej_d;

  // Reject count saturates rather than wrapping so a stuck-high LFSR stays visible.
  always_comb begin
    rej_d = rej_q;
    if (flush_i) begin
      rej_d = '0;
    end else if (draw && !cand_ok && rej_q != 16'hFFFF) begin
      rej_d = rej_q + 16'd1;
    end
  end

  // Reject counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rej_q <= '0;
    else         rej_q <= rej_d;
  end

  assign rejects_o = rej_q;
`endif

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cand_mod),
    .rdata_o (sample_o),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o = !fifo_empty;
  assign level_o = fifo_level;

endmodule

// File: tb/tb_rand_sampler.sv
// Self-checking bench for rand_sampler with RANGE=6, STRIDE=8, DEPTH=4.
module tb_rand_sampler;

  localparam int RANGE  = 6;
  localparam int STRIDE = 8;
  localparam int DEPTH  = 4;
  localparam int THRESH = 252;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] rand_i;
  logic       en_i, flush_i, ready_i;
  logic [7:0] sample_o;
  logic       valid_o;
  logic [2:0] level_o;
`ifdef RAND_SAMPLER_STATS_EN
  logic [15:0] rejects_o;
`endif

  rand_sampler #(
    .RANGE  (RANGE),
    .STRIDE (STRIDE),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rand_i   (rand_i),
    .en_i     (en_i),
    .flush_i  (flush_i),
    .sample_o (sample_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .level_o  (level_o)
`ifdef RAND_SAMPLER_STATS_EN
    ,
    .rejects_o (rejects_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  byte unsigned sb[$];
  int m_cnt;
  int m_state;  // 0 idle, 1 fill, 2 hold

  task automatic model_reset();
    sb.delete();
    m_cnt   = 0;
    m_state = 0;
  endtask

  // Drive one cycle, advance the reference model, check popped samples against the scoreboard.
  task automatic tick(input logic en, input logic fl, input logic rdy, input logic [7:0] rnd);
    bit pop, draw, push;
    int sz, ns;
    en_i = en; flush_i = fl; ready_i = rdy; rand_i = rnd;
    sz = sb.size();
    if (fl) begin
      sb.delete();
      m_cnt   = 0;
      m_state = en ? 1 : 0;
    end else begin
      pop = (sz != 0) && rdy;
      if (pop) begin
        tests_run++;
        if (sample_o !== sb[0]) begin
          tests_failed++;
          $display("FAIL pop_order: got %0d expected %0d", sample_o, sb[0]);
        end
        void'(sb.pop_front());
      end
      draw = en && (m_cnt == STRIDE - 1) && (m_state == 1);
      push = draw && (int'(rnd) < THRESH) && (sz < DEPTH);
      if (!en) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1) ns = (push && !pop && sz == DEPTH - 1) ? 2 : 1;
      else ns = pop ? 1 : 2;
      if (en && m_state != 2) m_cnt = (m_cnt == STRIDE - 1) ? 0 : m_cnt + 1;
      m_state = ns;
      if (push) sb.push_back(8'(int'(rnd) % RANGE));
    end
    @(posedge clk_i); #1;
  endtask

  // One full stride with ready held, given value presented on the draw edge.
  task automatic stride(input logic rdy, input logic [7:0] val);
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, rdy, 8'($urandom_range(0, 255)));
    tick(1'b1, 1'b0, rdy, val);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; en_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0; rand_i = 8'd0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0d expected 0", valid_o); end
    tests_run++;
    if (sample_o !== 8'd0) begin tests_failed++; $display("FAIL reset_sample: got %0d expected 0", sample_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_accept();
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL accept_early: got level %0d expected 0", level_o); end
    tick(1'b1, 1'b0, 1'b0, 8'd251);
    tests_run++;
    if (valid_o !== 1'b1) begin tests_failed++; $display("FAIL accept_valid: got %0d expected 1", valid_o); end
    tests_run++;
    if (sample_o !== 8'd5) begin tests_failed++; $display("FAIL accept_sample: got %0d expected 5", sample_o); end
    tests_run++;
    if (level_o !== 3'd1) begin tests_failed++; $display("FAIL accept_level: got %0d expected 1", level_o); end
    drain();
  endtask

  task automatic test_reject();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    stride(1'b0, 8'd252);
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL reject_252: got level %0d expected 0", level_o); end
`ifdef RAND_SAMPLER_STATS_EN
    tests_run++;
    if (rejects_o !== 16'd1) begin tests_failed++; $display("FAIL reject_count: got %0d expected 1", rejects_o); end
`endif
    stride(1'b0, 8'd255);
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL reject_255: got valid %0d expected 0", valid_o); end
    stride(1'b0, 8'd0);
    stride(1'b0, 8'd250);
    tests_run++;
    if (level_o !== 3'd2) begin tests_failed++; $display("FAIL accept_low_high: got level %0d expected 2", level_o); end
    tests_run++;
    if (sample_o !== 8'd0) begin tests_failed++; $display("FAIL accept_zero_head: got %0d expected 0", sample_o); end
    drain();
  endtask

  task automatic test_fill_hold();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    for (int d = 0; d < DEPTH; d++) stride(1'b0, 8'($urandom_range(0, THRESH - 1)));
    tests_run++;
    if (level_o !== 3'd4) begin tests_failed++; $display("FAIL hold_full: got level %0d expected 4", level_o); end
    for (int i = 0; i < 2 * STRIDE; i++) tick(1'b1, 1'b0, 1'b0, 8'd10);
    tests_run++;
    if (level_o !== 3'd4) begin tests_failed++; $display("FAIL hold_stays: got level %0d expected 4", level_o); end
    tick(1'b1, 1'b0, 1'b1, 8'd10);
    tests_run++;
    if (level_o !== 3'd3) begin tests_failed++; $display("FAIL hold_pop: got level %0d expected 3", level_o); end
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, 1'b0, 8'd100);
    tests_run++;
    if (level_o !== 3'd3) begin tests_failed++; $display("FAIL resume_early: got level %0d expected 3", level_o); end
    tick(1'b1, 1'b0, 1'b0, 8'd100);
    tests_run++;
    if (level_o !== 3'd4) begin tests_failed++; $display("FAIL resume_push: got level %0d expected 4", level_o); end
    drain();
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    stride(1'b0, 8'd13);
    stride(1'b0, 8'd29);
    tests_run++;
    if (level_o !== 3'd2) begin tests_failed++; $display("FAIL b2b_pre: got level %0d expected 2", level_o); end
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, 1'b0, 8'd7);
    tick(1'b1, 1'b0, 1'b1, 8'd44);
    tests_run++;
    if (level_o !== 3'd2) begin tests_failed++; $display("FAIL b2b_level: got level %0d expected 2", level_o); end
    tests_run++;
    if (sample_o !== 8'd5) begin tests_failed++; $display("FAIL b2b_head: got %0d expected 5", sample_o); end
    drain();
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    for (int d = 0; d < 3; d++) stride(1'b0, 8'($urandom_range(0, THRESH - 1)));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'd1);
    tests_run++;
    if (level_o !== 3'd3) begin tests_failed++; $display("FAIL flush_pre: got level %0d expected 3", level_o); end
    tick(1'b1, 1'b1, 1'b1, 8'd1);
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL flush_level: got %0d expected 0", level_o); end
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_valid: got %0d expected 0", valid_o); end
    tests_run++;
    if (sample_o !== 8'd0) begin tests_failed++; $display("FAIL flush_sample: got %0d expected 0", sample_o); end
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, 1'b0, 8'd3);
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL flush_cnt_clear: got level %0d expected 0", level_o); end
    tick(1'b1, 1'b0, 1'b0, 8'd3);
    tests_run++;
    if (level_o !== 3'd1) begin tests_failed++; $display("FAIL flush_first_draw: got level %0d expected 1", level_o); end
    drain();
  endtask

  task automatic test_enable_gap();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 8'd9);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 8'd9);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'd9);
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL gap_early: got level %0d expected 0", level_o); end
    tick(1'b1, 1'b0, 1'b0, 8'd9);
    tests_run++;
    if (level_o !== 3'd1) begin tests_failed++; $display("FAIL gap_draw: got level %0d expected 1", level_o); end
    tests_run++;
    if (sample_o !== 8'd3) begin tests_failed++; $display("FAIL gap_sample: got %0d expected 3", sample_o); end
    drain();
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b1, 1'b0, 8'd0);
    stride(1'b0, 8'd20);
    stride(1'b0, 8'd21);
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if (level_o !== 3'd2) begin tests_failed++; $display("FAIL areset_pre: got level %0d expected 2", level_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL areset_level: got %0d expected 0", level_o); end
    tests_run++;
    if (valid_o !== 1'b0) begin tests_failed++; $display("FAIL areset_valid: got %0d expected 0", valid_o); end
    tests_run++;
    if (sample_o !== 8'd0) begin tests_failed++; $display("FAIL areset_sample: got %0d expected 0", sample_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < STRIDE - 1; i++) tick(1'b1, 1'b0, 1'b0, 8'd50);
    tests_run++;
    if (level_o !== 3'd0) begin tests_failed++; $display("FAIL areset_early: got level %0d expected 0", level_o); end
    tick(1'b1, 1'b0, 1'b0, 8'd50);
    tests_run++;
    if (level_o !== 3'd1) begin tests_failed++; $display("FAIL areset_first: got level %0d expected 1", level_o); end
    drain();
  endtask

  initial begin
    test_reset();
    test_accept();
    test_reject();
    test_fill_hold();
    test_back_to_back();
    test_flush();
    test_enable_gap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
